// File: rtl/display_share_arbiter.sv
// Two-requester round-robin arbiter for the shared four-digit seven-segment display.
// The owner keeps the display for at least HOLD_CYCLES clocks. Define
// DISPLAY_SHARE_ARBITER_BLINK_EN to blink the owner's digits while the other requester waits.
module display_share_arbiter #(
    parameter int         HOLD_CYCLES  = 1000000,
    parameter logic [3:0] BLANK_DIGIT  = 4'hF,
    parameter int         BLINK_PERIOD = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4
);

    localparam int               CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [15:0]      BLANK   = {4{BLANK_DIGIT}};

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("display_share_arbiter: HOLD_CYCLES must be at least 2");
    end
    if (BLINK_PERIOD < 1) begin : g_bad_blink
        $error("display_share_arbiter: BLINK_PERIOD must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             rr_q, rr_d;          // index of the requester that wins the next tie
    logic [15:0]      data_q, data_d;      // digits currently owned (blank when idle)
    logic             gnt0_q, gnt1_q;

    logic             own_req, oth_req;
    logic [15:0]      own_data, oth_data;
    state_t           oth_state;
    logic             expired;

    // Fold OWN0/OWN1 into one owner/other view so the release rules are written once.
    always_comb begin
        own_req   = (state_q == OWN1) ? req1  : req0;
        oth_req   = (state_q == OWN1) ? req0  : req1;
        own_data  = (state_q == OWN1) ? data1 : data0;
        oth_data  = (state_q == OWN1) ? data0 : data1;
        oth_state = (state_q == OWN1) ? OWN0  : OWN1;
        expired   = (hold_q == CNT_MAX);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                data_d = BLANK;
                if (req0 && (!req1 || !rr_q)) begin
                    state_d = OWN0;
                    hold_d  = '0;
                    rr_d    = 1'b1;
                    data_d  = data0;
                end else if (req1) begin
                    state_d = OWN1;
                    hold_d  = '0;
                    rr_d    = 1'b0;
                    data_d  = data1;
                end
            end
            OWN0, OWN1: begin
                if (expired && oth_req) begin
                    // Direct handover: no idle bubble between owners.
                    state_d = oth_state;
                    hold_d  = '0;
                    rr_d    = (oth_state == OWN1) ? 1'b0 : 1'b1;
                    data_d  = oth_data;
                end else if (expired && !own_req) begin
                    state_d = IDLE;
                    data_d  = BLANK;
                end else begin
                    if (!expired) begin
                        hold_d = hold_q + 1'b1;
                    end
                    // A dropped owner keeps the grant but its digits freeze.
                    if (own_req) begin
                        data_d = own_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = BLANK;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rr_q    <= 1'b0;
            data_q  <= BLANK;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            gnt0_q  <= (state_d == OWN0);
            gnt1_q  <= (state_d == OWN1);
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign busy = gnt0_q | gnt1_q;

`ifdef DISPLAY_SHARE_ARBITER_BLINK_EN
    localparam int            BW        = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIOD - 1);

    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;       // 1 = blank half-phase
    logic [15:0]   disp_q;
    logic          pending;

    always_comb begin
        pending = (state_q != IDLE) && oth_req;
        blink_d = '0;
        phase_d = 1'b0;
        if (pending && (state_d == state_q)) begin
            if (blink_q == BLINK_MAX) begin
                phase_d = !phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
            phase_q <= 1'b0;
            disp_q  <= BLANK;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
            disp_q  <= phase_d ? BLANK : data_d;
        end
    end

    assign {d4, d3, d2, d1} = disp_q;
`else
    assign {d4, d3, d2, d1} = data_q;
`endif

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench for display_share_arbiter: directed literal cases plus a randomized
// run compared every cycle against an owner/tenure model of the arbitration rules.
module tb_display_share_arbiter;

    localparam int          HOLD  = 8;
    localparam int          BP    = 2;
    localparam logic [15:0] BLANK = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] data0 = '0, data1 = '0;
    logic        gnt0, gnt1, busy;
    logic [3:0]  d1, d2, d3, d4;

    int n_cmp  = 0;
    int n_fail = 0;

    display_share_arbiter #(
        .HOLD_CYCLES (HOLD),
        .BLANK_DIGIT (4'hF),
        .BLINK_PERIOD(BP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req0 (req0),
        .data0(data0),
        .req1 (req1),
        .data1(data1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .busy (busy),
        .d1   (d1),
        .d2   (d2),
        .d3   (d3),
        .d4   (d4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the display, how many cycles it has held it, whose turn a tie is,
    // which digits it shows, and how many consecutive cycles a handover has been waiting.
    typedef struct {
        int          owner;    // -1 = nobody
        int          held;
        int          rr;
        logic [15:0] data;
        int          pend;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.owner = -1;
        s.held  = 0;
        s.rr    = 0;
        s.data  = BLANK;
        s.pend  = 0;
        return s;
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic r0, input logic r1,
                                  input logic [15:0] a, input logic [15:0] b);
        mdl_t        n;
        logic        rq[2];
        logic [15:0] dv[2];
        int          win;
        int          oth;
        logic        waiting;
        n = s;
        rq[0] = r0; rq[1] = r1;
        dv[0] = a;  dv[1] = b;
        win = -1;
        waiting = (s.owner >= 0) && rq[1 - s.owner];
        if (s.owner < 0) begin
            if (r0 && r1) win = s.rr;
            else if (r0)  win = 0;
            else if (r1)  win = 1;
            if (win >= 0) begin
                n.owner = win;
                n.held  = 1;
                n.rr    = 1 - win;
                n.data  = dv[win];
            end
        end else begin
            oth = 1 - s.owner;
            if (s.held >= HOLD && rq[oth]) begin
                n.owner = oth;
                n.held  = 1;
                n.rr    = s.owner;
                n.data  = dv[oth];
            end else if (s.held >= HOLD && !rq[s.owner]) begin
                n.owner = -1;
                n.data  = BLANK;
            end else begin
                n.held = s.held + 1;
                if (rq[s.owner]) n.data = dv[s.owner];
            end
        end
        n.pend = (n.owner != s.owner || !waiting) ? 0 : s.pend + 1;
        return n;
    endfunction

    function automatic logic [15:0] exp_digits(input mdl_t s);
        logic blank_phase;
        blank_phase = 1'b0;
`ifdef DISPLAY_SHARE_ARBITER_BLINK_EN
        blank_phase = ((s.pend / BP) % 2) == 1;
`endif
        return (s.owner < 0 || blank_phase) ? BLANK : s.data;
    endfunction

    mdl_t m = mdl_reset();

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mdl_reset();
        else       m <= step(m, req0, req1, data0, data1);
    end

    always @(negedge clk) begin
        check("model_gnt0",   {31'd0, gnt0}, {31'd0, m.owner == 0});
        check("model_gnt1",   {31'd0, gnt1}, {31'd0, m.owner == 1});
        check("model_busy",   {31'd0, busy}, {31'd0, m.owner >= 0});
        check("model_digits", {16'd0, d4, d3, d2, d1}, {16'd0, exp_digits(m)});
        check("one_hot",      {31'd0, gnt0 & gnt1}, 32'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        cyc();
        cyc();
        check("rst_gnt0",   {31'd0, gnt0}, 32'd0);
        check("rst_gnt1",   {31'd0, gnt1}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_digits", {16'd0, d4, d3, d2, d1}, 32'h0000FFFF);
        reset = 1'b0;

        // Single requester: grant and digits one edge later, released HOLD cycles after grant.
        req0 = 1'b1; data0 = 16'h1234;
        cyc();
        check("first_gnt0",   {31'd0, gnt0}, 32'd1);
        check("first_busy",   {31'd0, busy}, 32'd1);
        check("first_digits", {16'd0, d4, d3, d2, d1}, 32'h00001234);
        req0 = 1'b0;
        for (int k = 2; k <= HOLD + 1; k++) begin
            cyc();
            check("single_hold_gnt0", {31'd0, gnt0}, {31'd0, k <= HOLD});
        end
        check("single_idle_digits", {16'd0, d4, d3, d2, d1}, 32'h0000FFFF);

        // Continuous contention from reset: 8 cycles each, requester 0 first.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 16'hAAAA; data1 = 16'h5555;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            check("contend_gnt0", {31'd0, gnt0}, {31'd0, (k <= 8) || (k == 17)});
            check("contend_gnt1", {31'd0, gnt1}, {31'd0, (k >= 9) && (k <= 16)});
        end

        // Owner drops inside the hold window: digits freeze on BEEF, then blank at expiry.
        do_reset();
        req0 = 1'b1; data0 = 16'h1111;
        cyc();
        data0 = 16'hBEEF;
        cyc();
        req0 = 1'b0;
        for (int k = 3; k <= 9; k++) begin
            cyc();
            data0 = 16'hCAFE;
            check("drop_gnt0",   {31'd0, gnt0}, {31'd0, k <= 8});
            check("drop_digits", {16'd0, d4, d3, d2, d1}, (k <= 8) ? 32'h0000BEEF : 32'h0000FFFF);
        end

        // Short req1 pulse during req0's hold is lost.
        do_reset();
        req0 = 1'b1; data0 = 16'h5A5A; data1 = 16'h0F0F;
        cyc();
        req1 = 1'b1;
        cyc();
        cyc();
        req1 = 1'b0;
        for (int k = 4; k <= 20; k++) begin
            cyc();
            check("pulse_gnt1", {31'd0, gnt1}, 32'd0);
            check("pulse_gnt0", {31'd0, gnt0}, 32'd1);
        end

        // Pending handover: steady 1234 by default, 2-on/2-off blink when the feature is built in.
        do_reset();
        req0 = 1'b1; data0 = 16'h1234; data1 = 16'h9876;
        cyc();
        req1 = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            cyc();
            check("handover_gnt1", {31'd0, gnt1}, {31'd0, k == 9});
            if (k <= 8) begin
`ifdef DISPLAY_SHARE_ARBITER_BLINK_EN
                check("blink_digits", {16'd0, d4, d3, d2, d1},
                      (((k - 1) / 2) % 2 == 1) ? 32'h0000FFFF : 32'h00001234);
`else
                check("steady_digits", {16'd0, d4, d3, d2, d1}, 32'h00001234);
`endif
            end
        end
        check("handover_digits", {16'd0, d4, d3, d2, d1}, 32'h00009876);

        // Asynchronous reset mid-grant: outputs clear before any clock edge.
        do_reset();
        req0 = 1'b1; data0 = 16'hABCD;
        cyc();
        cyc();
        check("pre_async_gnt0", {31'd0, gnt0}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_gnt0",   {31'd0, gnt0}, 32'd0);
        check("async_gnt1",   {31'd0, gnt1}, 32'd0);
        check("async_busy",   {31'd0, busy}, 32'd0);
        check("async_digits", {16'd0, d4, d3, d2, d1}, 32'h0000FFFF);
        cyc();
        reset = 1'b0;

        // Randomized traffic with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
            end
            if ($urandom_range(7) == 0) req0 = ~req0;
            if ($urandom_range(7) == 0) req1 = ~req1;
            if ($urandom_range(2) == 0) data0 = 16'($urandom);
            if ($urandom_range(2) == 0) data1 = 16'($urandom);
            cyc();
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
